// File: rtl/img_stream_ctrl.sv
// Frame-read sequencer: walks a synchronous frame memory in raster order and
// streams the pixels through a 4-entry skid FIFO onto a valid/ready bus.
module img_stream_ctrl #(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              out_ready,
  output logic [7:0]        bus_out,
  output logic              out_valid,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic       sof;
    logic       eol;
    logic       eof;
    logic [7:0] pix;
  } entry_t;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q;
  logic [2:0]        tag_q;
  entry_t            fifo_q [4];
  logic [1:0]        wr_ptr_q, rd_ptr_q;
  logic [2:0]        cnt_q;

  logic   issue_sof, issue_eol, issue_eof;
  logic   pop;
  entry_t head;

  assign issue_sof = (x_q == '0) && (y_q == '0);
  assign issue_eol = (x_q == X_LAST);
  assign issue_eof = issue_eol && (y_q == Y_LAST);

  assign head      = fifo_q[rd_ptr_q];
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    mem_en  = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        // credit: buffered plus in-flight reads never exceed FIFO depth
        mem_en = (cnt_q + {2'b00, inflight_q}) < 3'd4;
        if (mem_en && issue_eof) state_d = S_DRAIN;
      end
      S_DRAIN: if (pop && head.eof) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= mem_en;
      if (mem_en) begin
        tag_q  <= {issue_sof, issue_eol, issue_eof};
        addr_q <= issue_eof ? '0 : addr_q + ADDR_W'(1);
        if (issue_eol) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? '0 : y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
      if (inflight_q) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)        rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({inflight_q, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // read data lands one cycle after issue, paired with the tags captured then
  always_ff @(posedge clk) begin
    if (!rst && inflight_q) fifo_q[wr_ptr_q] <= entry_t'({tag_q, mem_rdata});
  end

  assign mem_addr = addr_q;
  assign bus_out  = out_valid ? head.pix : '0;
  assign sof      = out_valid && head.sof;
  assign eol      = out_valid && head.eol;
  assign eof      = out_valid && head.eof;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_img_stream_ctrl.sv
// Bench for img_stream_ctrl: directed timeline checks plus a queue-based
// scoreboard of issued addresses against accepted pixels and their markers.
module tb_img_stream_ctrl;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          out_ready;
  logic [7:0]    bus_out;
  logic          out_valid, sof, eol, eof, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;

  logic [7:0] mem [16];
  int         issued [$];
  int         exp_addr    = 0;
  bit         eof_hs_prev = 1'b0;
  bit         prev_stall  = 1'b0;
  logic [10:0] prev_out   = '0;

  img_stream_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_ready(out_ready), .bus_out(bus_out),
    .out_valid(out_valid), .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // synchronous frame memory: data one cycle after the enable
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      issued.delete();
      exp_addr    = 0;
      eof_hs_prev = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      check_val("done_after_eof", done, eof_hs_prev);
      if (!out_valid) begin
        check_val("idle_bus", bus_out, 0);
        check_val("idle_tags", {sof, eol, eof}, 0);
      end
      if (prev_stall) begin
        check_val("stall_valid", out_valid, 1);
        check_val("stall_hold", {sof, eol, eof, bus_out}, prev_out);
      end
      if (!busy) check_val("idle_mem_en", mem_en, 0);
      if (mem_en) begin
        check_val("mem_addr", mem_addr, exp_addr);
        issued.push_back(exp_addr);
        exp_addr = (exp_addr + 1) % N;
      end
      if (issued.size() > 4) check_val("outstanding", issued.size(), 4);
      if (out_valid && out_ready) begin
        if (issued.size() == 0) begin
          check_val("hs_unexpected", 1, 0);
        end else begin
          int idx;
          idx = issued.pop_front();
          check_val("hs_pixel", bus_out, mem[idx]);
          check_val("hs_tags", {sof, eol, eof},
                    {idx == 0, (idx % W) == W - 1, idx == N - 1});
        end
        hs_cnt++;
      end
      eof_hs_prev = out_valid && out_ready && eof;
      prev_stall  = out_valid && !out_ready;
      prev_out    = {sof, eol, eof, bus_out};
    end
  end

  task automatic wait_done(input int limit, input bit rnd, input bit noise);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      if (rnd)   out_ready = ($urandom_range(0, 3) != 0);
      if (noise) start = ($urandom_range(0, 7) == 0);
      #3;
      seen = done;
      if (!seen) tick();
    end
    if (noise) start = 1'b0;
    out_ready = 1'b1;
    check_val("done_seen", seen, 1);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check_val(tag, {mem_en, mem_addr, bus_out, out_valid, sof, eol, eof, busy, done}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
    tick(); tick();
    rst = 1'b0;
    #3;
    check_all_zero("reset_state");
    tick();

    // nominal frame, exact timeline
    out_ready = 1'b1;
    start = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      start = (c == 0);
      #3;
      check_val("t1_mem_en", mem_en, (c >= 1 && c <= 8));
      if (c >= 1 && c <= 8) check_val("t1_addr", mem_addr, c - 1);
      check_val("t1_valid", out_valid, (c >= 3 && c <= 10));
      check_val("t1_bus", bus_out, (c >= 3 && c <= 10) ? c + 13 : 0);
      check_val("t1_sof", sof, c == 3);
      check_val("t1_eol", eol, c == 6 || c == 10);
      check_val("t1_eof", eof, c == 10);
      check_val("t1_done", done, c == 11);
      check_val("t1_busy", busy, (c >= 1 && c <= 11));
      tick();
    end

    // downstream stall in cycles 5..8
    hs_cnt = 0;
    for (int c = 0; c <= 12; c++) begin
      start = (c == 0);
      out_ready = !(c >= 5 && c <= 8);
      #3;
      if (c >= 5 && c <= 8) begin
        check_val("t2_hold_valid", out_valid, 1);
        check_val("t2_hold_bus", bus_out, 18);
      end
      if (c == 7 || c == 8) check_val("t2_credit_stop", mem_en, 0);
      tick();
    end
    wait_done(50, 1'b0, 1'b0);
    check_val("t2_pixels", hs_cnt, N);

    // start during RUN is ignored
    hs_cnt = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(50, 1'b0, 1'b0);
    check_val("t3_pixels", hs_cnt, N);
    for (int i = 0; i < 4; i++) begin
      #3;
      check_val("t3_no_restart", busy, 0);
      tick();
    end

    // reset mid-frame, then a clean restart
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    #3;
    check_all_zero("t4_after_rst");
    tick();
    hs_cnt = 0;
    start = 1'b1; tick(); start = 1'b0;
    #3;
    check_val("t4_restart_en", mem_en, 1);
    check_val("t4_restart_addr", mem_addr, 0);
    tick();
    wait_done(50, 1'b0, 1'b0);
    check_val("t4_pixels", hs_cnt, N);

    // idle without start
    for (int i = 0; i < 20; i++) begin
      #3;
      check_val("t5_idle", {bus_out, out_valid, mem_en}, 0);
      tick();
    end

    // start held high: back-to-back frames
    start = 1'b1;
    wait_done(50, 1'b0, 1'b0);
    #3;
    check_val("t6_idle_gap", busy, 0);
    tick();
    #3;
    check_val("t6_second_en", mem_en, 1);
    check_val("t6_second_addr", mem_addr, 0);
    start = 1'b0;
    tick();
    wait_done(50, 1'b0, 1'b0);

    // randomized data, back-pressure and stray start pulses
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
      hs_cnt = 0;
      start = 1'b1; tick(); start = 1'b0;
      wait_done(300, 1'b1, 1'b1);
      check_val("rnd_pixels", hs_cnt, N);
      tick(); tick();
    end

    check_val("scoreboard_empty", issued.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
